// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared cache/memory definitions: bus widths and the
//               responder FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

  localparam int c_ADDR_W = 32;
  localparam int c_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_sp_ram.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram
// Description : Single-port word array with synchronous write and registered
//               read (read-before-write), shaped for block-RAM inference.
//               Contents power up as zero or as the INIT_FILE image.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram #(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 10,
  parameter     INIT_FILE = ""
) (
  input  logic              iCLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] r_mem [0:(2**IDX_W)-1] = '{default: '0};

  // Write port and registered read share one address; read returns old data.
  always_ff @(posedge iCLK) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    rdata <= r_mem[idx];
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Fixed-latency memory model answering cache requests. A request
//               seen in IDLE is captured, held for LATENCY cycles, and answered
//               with a one-cycle ready pulse. Writes commit on the edge that
//               enters RESP; reads return the array word during RESP.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W    = c_ADDR_W,
  parameter int DATA_W    = c_DATA_W,
  parameter int DEPTH_W   = 10,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] cache2mem_addr,
  input  logic [DATA_W-1:0] cache2mem_data,
  input  logic              cache2mem_MemWrite,
  input  logic              cache2mem_MemRead,
  output logic [DATA_W-1:0] mem2cache_data,
  output logic              mem2cache_ready,
  output logic              oBUSY
);

  localparam logic [7:0] c_LOAD = 8'(LATENCY - 1);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_cnt;
  logic                r_wr;
  logic [DEPTH_W-1:0]  r_idx;
  logic [DATA_W-1:0]   r_data;

  logic                w_req;
  logic                w_commit;
  logic [DEPTH_W-1:0]  w_ram_idx;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [DATA_W-1:0]  w_ram_rdata;

  // Byte-lane and high address bits are deliberately ignored (aliasing).
  logic                w_unused_addr;
  assign w_unused_addr = ^{cache2mem_addr[ADDR_W-1:DEPTH_W+2], cache2mem_addr[1:0]};

  assign w_req = cache2mem_MemRead | cache2mem_MemWrite;

  // Next-state and commit decode; a write commits on the edge entering RESP.
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (LATENCY == 1) begin
            w_next   = RESP;
            w_commit = cache2mem_MemWrite;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt <= 8'd1) begin
          w_next   = RESP;
          w_commit = r_wr;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // In IDLE the array sees the live request so LATENCY=1 can commit/read at once.
  assign w_ram_idx   = (r_state == IDLE) ? cache2mem_addr[DEPTH_W+1:2] : r_idx;
  assign w_ram_wdata = (r_state == IDLE) ? cache2mem_data : r_data;

  // State register, request capture and latency countdown.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_wr   <= cache2mem_MemWrite;
        r_idx  <= cache2mem_addr[DEPTH_W+1:2];
        r_data <= cache2mem_data;
        r_cnt  <= c_LOAD;
      end else if (r_state == WAIT && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  sp_ram #(
    .DATA_W    (DATA_W),
    .IDX_W     (DEPTH_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .iCLK  (iCLK),
    .we    (w_commit),
    .idx   (w_ram_idx),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  // Output gating: a write answers with its own data, avoiding read-during-write.
  always_comb begin
    mem2cache_ready = (r_state == RESP);
    oBUSY           = (r_state != IDLE);
    mem2cache_data  = '0;
    if (r_state == RESP) begin
      mem2cache_data = r_wr ? r_data : w_ram_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed bench: a LATENCY=4 instance driven from a vector
//               table plus reset/back-to-back sequences, and LATENCY=1/7
//               instances for the latency sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rdy   [3];
  logic        busy  [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic        chg;
    logic        chkd;
    logic [31:0] expd;
  } vec_t;

  vec_t vecs [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4)) u_l4 (
    .iCLK(clk), .iRST(rst),
    .cache2mem_addr(addr[0]), .cache2mem_data(wdata[0]),
    .cache2mem_MemWrite(wr[0]), .cache2mem_MemRead(rd[0]),
    .mem2cache_data(rdata[0]), .mem2cache_ready(rdy[0]), .oBUSY(busy[0])
  );

  mem_responder #(.LATENCY(1)) u_l1 (
    .iCLK(clk), .iRST(rst),
    .cache2mem_addr(addr[1]), .cache2mem_data(wdata[1]),
    .cache2mem_MemWrite(wr[1]), .cache2mem_MemRead(rd[1]),
    .mem2cache_data(rdata[1]), .mem2cache_ready(rdy[1]), .oBUSY(busy[1])
  );

  mem_responder #(.LATENCY(7)) u_l7 (
    .iCLK(clk), .iRST(rst),
    .cache2mem_addr(addr[2]), .cache2mem_data(wdata[2]),
    .cache2mem_MemWrite(wr[2]), .cache2mem_MemRead(rd[2]),
    .mem2cache_data(rdata[2]), .mem2cache_ready(rdy[2]), .oBUSY(busy[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Called at posedge+1 of an IDLE cycle; checks every cycle through the
  // response and the idle cycle after it.
  task automatic run_txn(input int i, input int lat, input string tag,
                         input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic chg, input logic chkd, input logic [31:0] expd);
    wr[i] = w; rd[i] = r; addr[i] = a; wdata[i] = d;
    for (int n = 1; n <= lat + 1; n++) begin
      @(posedge clk); #1;
      check($sformatf("%s c%0d ready", tag, n), 32'(rdy[i]), 32'(n == lat));
      check($sformatf("%s c%0d busy", tag, n), 32'(busy[i]), 32'(n <= lat));
      if (n == lat) begin
        if (chkd) check($sformatf("%s c%0d data", tag, n), rdata[i], expd);
        wr[i] = 1'b0; rd[i] = 1'b0;
      end else begin
        check($sformatf("%s c%0d data0", tag, n), rdata[i], 32'd0);
      end
      if (n == 1 && chg && lat > 1) begin
        addr[i] = a + 32'd4; wdata[i] = ~d; wr[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p1, p2, np;

    //        w     r     addr      data    chg   chkd  expd
    vecs[0] = '{1'b1, 1'b0, 32'd4,    32'd5,  1'b0, 1'b0, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 32'd4,    32'd0,  1'b0, 1'b1, 32'd5};
    vecs[2] = '{1'b0, 1'b1, 32'd4,    32'd0,  1'b0, 1'b1, 32'd5};
    vecs[3] = '{1'b1, 1'b0, 32'd4100, 32'd20, 1'b0, 1'b0, 32'd0};
    vecs[4] = '{1'b0, 1'b1, 32'd4,    32'd0,  1'b0, 1'b1, 32'd20};
    vecs[5] = '{1'b0, 1'b1, 32'd6,    32'd0,  1'b0, 1'b1, 32'd20};
    vecs[6] = '{1'b1, 1'b1, 32'd12,   32'd15, 1'b1, 1'b1, 32'd15};
    vecs[7] = '{1'b0, 1'b1, 32'd12,   32'd0,  1'b0, 1'b1, 32'd15};
    vecs[8] = '{1'b0, 1'b1, 32'd16,   32'd0,  1'b0, 1'b1, 32'd0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d ready", i), 32'(rdy[i]), 32'd0);
      check($sformatf("reset%0d busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("reset%0d data", i), rdata[i], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 2; v++)
      run_txn(0, 4, $sformatf("vec%0d", v), vecs[v].w, vecs[v].r, vecs[v].a,
              vecs[v].d, vecs[v].chg, vecs[v].chkd, vecs[v].expd);

    // Reset in WAIT of a write of 56 to addr 4: aborted, nothing committed.
    wr[0] = 1'b1; addr[0] = 32'd4; wdata[0] = 32'd56;
    @(posedge clk); #1;
    check("rstwait busy_in_wait", 32'(busy[0]), 32'd1);
    rst = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    check("rstwait busy", 32'(busy[0]), 32'd0);
    check("rstwait ready", 32'(rdy[0]), 32'd0);
    check("rstwait data", rdata[0], 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      check($sformatf("rstwait no_ready c%0d", n), 32'(rdy[0]), 32'd0);
    end

    for (int v = 2; v < 9; v++)
      run_txn(0, 4, $sformatf("vec%0d", v), vecs[v].w, vecs[v].r, vecs[v].a,
              vecs[v].d, vecs[v].chg, vecs[v].chkd, vecs[v].expd);

    // Back-to-back: read strobe held until the second ready pulse.
    rd[0] = 1'b1; addr[0] = 32'd4;
    p1 = -1; p2 = -1; np = 0;
    for (int c = 1; c <= 30 && np < 2; c++) begin
      @(posedge clk); #1;
      if (rdy[0]) begin
        np++;
        if (np == 1) p1 = c;
        else begin p2 = c; rd[0] = 1'b0; end
      end
    end
    rd[0] = 1'b0;
    check("b2b pulses", 32'(np), 32'd2);
    check("b2b first", 32'(p1), 32'd4);
    check("b2b spacing", 32'(p2 - p1), 32'd5);
    @(posedge clk); #1;

    // Latency sweep: word 234 placed at addr 8, then read back.
    run_txn(1, 1, "l1 wr", 1'b1, 1'b0, 32'd8, 32'd234, 1'b0, 1'b0, 32'd0);
    run_txn(1, 1, "l1 rd", 1'b0, 1'b1, 32'd8, 32'd0,   1'b0, 1'b1, 32'd234);
    run_txn(2, 7, "l7 wr", 1'b1, 1'b0, 32'd8, 32'd234, 1'b0, 1'b0, 32'd0);
    run_txn(2, 7, "l7 rd", 1'b0, 1'b1, 32'd8, 32'd0,   1'b0, 1'b1, 32'd234);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
